// File: rtl/drop_sequencer.sv
// drop_sequencer: per-channel confirmed drop pulse sequencer with seven-segment status display
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   t_act, t_lim             per-channel current time and limit, channel i at [i*W +: W]
//   drop_en, rearm           per-channel drop request and SPENT->COLD return
//   disp_sel                 channel shown on the displays (>= CH blanks them)
//   seven_seg1..4            active-high segments [6:0]=g..a, seg1 leftmost
//   drop_activated           per-channel registered drop pulse
//   busy                     any channel pulsing
//   drop_count               (DROP_COUNT_EN only) saturating count of DROP entries
module drop_sequencer #(
    parameter int W = 16,
    parameter int CH = 4,
    parameter int CONFIRM = 3,
    parameter int DROP_LEN = 8,
    localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] t_act,
    input  logic [CH*W-1:0] t_lim,
    input  logic [CH-1:0]   drop_en,
    input  logic [CH-1:0]   rearm,
    input  logic [SW-1:0]   disp_sel,
    output logic [6:0]      seven_seg1,
    output logic [6:0]      seven_seg2,
    output logic [6:0]      seven_seg3,
    output logic [6:0]      seven_seg4,
    output logic [CH-1:0]   drop_activated,
`ifdef DROP_COUNT_EN
    output logic            busy,
    output logic [7:0]      drop_count
`else
    output logic            busy
`endif
);
    typedef enum logic [2:0] {COLD, CONFIRMING, DROP, SPENT, HOT} state_t;
    localparam logic [27:0] COLD_W = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
    localparam logic [27:0] DROP_W = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
    localparam logic [27:0] HOT_W  = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
    localparam logic [27:0] DONE_W = {7'b1011110, 7'b1011100, 7'b1010100, 7'b1111001};
    localparam logic [7:0] CONF_LAST = 8'(CONFIRM - 1);
    localparam logic [7:0] LEN_LAST = 8'(DROP_LEN - 1);
    state_t st_q [CH];
    state_t st_d [CH];
    logic [7:0] cnt_q [CH];
    logic [7:0] cnt_d [CH];
    logic [CH-1:0] lt, gt;
    logic [27:0] disp_q, disp_d;
    for (genvar g = 0; g < CH; g++) begin : g_cmp
        assign lt[g] = t_act[g*W +: W] < t_lim[g*W +: W];
        assign gt[g] = t_act[g*W +: W] > t_lim[g*W +: W];
    end
    function automatic logic [27:0] word(input state_t s);
        return s == DROP ? DROP_W : s == HOT ? HOT_W : s == SPENT ? DONE_W : COLD_W;
    endfunction
    // One counter per channel: confirm count in CONFIRMING, pulse length in DROP.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_d[i] = st_q[i];
            cnt_d[i] = cnt_q[i];
            case (st_q[i])
                COLD: begin
                    if (lt[i] && drop_en[i]) begin
                        if (CONFIRM == 1) begin
                            st_d[i] = DROP;
                            cnt_d[i] = 8'd0;
                        end else begin
                            st_d[i] = CONFIRMING;
                            cnt_d[i] = 8'd1;
                        end
                    end else if (gt[i] && drop_en[i]) st_d[i] = HOT;
                end
                CONFIRMING: begin
                    if (lt[i] && drop_en[i]) begin
                        if (cnt_q[i] == CONF_LAST) begin
                            st_d[i] = DROP;
                            cnt_d[i] = 8'd0;
                        end else cnt_d[i] = cnt_q[i] + 8'd1;
                    end else begin
                        st_d[i] = COLD;
                        cnt_d[i] = 8'd0;
                    end
                end
                DROP: begin
                    if (cnt_q[i] == LEN_LAST) begin
                        st_d[i] = SPENT;
                        cnt_d[i] = 8'd0;
                    end else cnt_d[i] = cnt_q[i] + 8'd1;
                end
                SPENT: if (rearm[i]) st_d[i] = COLD;
                HOT: if (!drop_en[i] || !gt[i]) st_d[i] = COLD;
                default: st_d[i] = COLD;
            endcase
        end
        disp_d = (int'(disp_sel) < CH) ? word(st_q[disp_sel]) : 28'd0;
    end
    // Pulse is registered from the current state, so it starts the cycle after DROP is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i] <= COLD;
                cnt_q[i] <= 8'd0;
            end
            drop_activated <= '0;
            disp_q <= COLD_W;
        end else begin
            for (int i = 0; i < CH; i++) begin
                st_q[i] <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                drop_activated[i] <= st_q[i] == DROP;
            end
            disp_q <= disp_d;
        end
    end
    assign busy = |drop_activated;
    assign {seven_seg1, seven_seg2, seven_seg3, seven_seg4} = disp_q;
`ifdef DROP_COUNT_EN
    logic [4:0] n_enter;
    logic [8:0] cnt_sum;
    always_comb begin
        n_enter = 5'd0;
        for (int i = 0; i < CH; i++) n_enter = n_enter + 5'((st_d[i] == DROP) && (st_q[i] != DROP));
    end
    assign cnt_sum = {1'b0, drop_count} + {4'b0, n_enter};
    always_ff @(posedge clk) begin
        if (rst) drop_count <= 8'd0;
        else drop_count <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
    end
`endif
endmodule

// File: doc/drop_sequencer.md
DROP_SEQUENCER -- requirements
Module: drop_sequencer

Interface
REQ-001 Parameter W, default 16, width of each time value (unsigned).
REQ-002 Parameter CH, default 4, number of independent drop channels (1..16).
REQ-003 Parameter CONFIRM, default 3, consecutive cycles a drop request must hold before firing (1..255).
REQ-004 Parameter DROP_LEN, default 8, drop pulse length in cycles (1..255).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 t_act  input  CH*W  current time per channel, channel i at bits [i*W +: W].
REQ-008 t_lim  input  CH*W  time limit per channel, same packing.
REQ-009 drop_en  input  CH  per-channel drop request.
REQ-010 rearm  input  CH  per-channel return from SPENT to COLD.
REQ-011 disp_sel  input  clog2(CH) (min 1)  channel shown on the displays.
REQ-012 seven_seg1..seven_seg4  output  7 each  active-high segments, bit order [6:0]=g,f,e,d,c,b,a; seg1 leftmost.
REQ-013 drop_activated  output  CH  per-channel drop pulse, registered.
REQ-014 busy  output  1  high while any channel is in DROP.

Function
REQ-015 Each channel shall run an independent FSM: COLD, CONFIRMING, DROP, SPENT, HOT.
REQ-016 Per channel: lt = t_act<t_lim, gt = t_act>t_lim, unsigned full-width compare; t_act==t_lim counts as neither.
REQ-017 COLD: lt&drop_en -> CONFIRMING with confirm counter = 1; gt&drop_en -> HOT; else stay.
REQ-018 CONFIRMING: lt&drop_en with counter==CONFIRM-1 -> DROP; lt&drop_en otherwise -> counter+1; any other condition -> COLD, counter cleared.
REQ-019 CONFIRM=1: COLD shall go directly to DROP when lt&drop_en.
REQ-020 DROP: drop_activated[i]=1 for exactly DROP_LEN cycles regardless of inputs, then -> SPENT; first high cycle is the cycle after DROP is entered.
REQ-021 SPENT: drop_activated[i]=0; ignores t_act/t_lim/drop_en; rearm[i] -> COLD.
REQ-022 HOT: leaves to COLD when drop_en[i]=0 or gt=0; a channel in HOT shall never drop without passing through COLD.
REQ-023 rearm[i] shall be ignored in every state except SPENT.
REQ-024 Display (registered, one-cycle latency from state change) shows the disp_sel channel: COLD/CONFIRMING "COLD" (0111001,1011100,0111000,1011110); DROP "DROP" (1011110,1010000,1011100,1110011); HOT " HOT" (0000000,1110110,1011100,1111000); SPENT "DONE" (1011110,1011100,1010100,1111001).
REQ-025 disp_sel >= CH shall show all four digits blank (0000000).
REQ-026 Counters shall be sized for 255 and never wrap; channels shall not share counters.

Reset
REQ-027 rst shall force every channel to COLD, clear all counters, drop_activated=0, busy=0, displays to "COLD" on the next clock edge.
REQ-028 rst asserted during DROP shall terminate the pulse on the next edge; no partial pulse resumes after release.

Configuration
REQ-029 Macro DROP_COUNT_EN: when defined, output drop_count (8 bits) shall increment by the number of channels entering DROP in that cycle, saturating at 255, cleared by rst; when undefined, drop_count and its logic shall not exist and all other behaviour is unchanged.

Verification
REQ-030 CH=4, CONFIRM=3, DROP_LEN=8; ch0 t_act=100,t_lim=200,drop_en=1 held -> drop_activated[0] high exactly 8 cycles starting 4 cycles after drop_en rises; then display "DONE" with disp_sel=0.
REQ-031 ch1 lt, drop_en=1 for 2 cycles then 0 -> no pulse, state back to COLD, display "COLD".
REQ-032 ch2 t_act=300,t_lim=200,drop_en=1 -> " HOT", no pulse; then t_act=100 with drop_en held -> HOT->COLD, then pulse after full confirm.
REQ-033 t_act=t_lim=500, drop_en=1 for 20 cycles -> stays COLD, no pulse.
REQ-034 ch0 and ch3 reach DROP on the same cycle -> both pulse independently, busy=1 for 8 cycles; with DROP_COUNT_EN drop_count +2.
REQ-035 rst asserted on cycle 3 of a pulse -> drop_activated=0 next edge, all channels COLD; rearm in COLD has no effect.
